// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, blocking icache request, F/D pipeline register,
// one-entry skid buffer for decode stalls and redirect handling with in-flight drain.
module fetch_stage #(
  parameter int unsigned     ILEN    = 32,
  parameter int unsigned     XLEN    = 32,
  parameter logic [XLEN-1:0] BOOT_PC = 'h0000_1000,
  parameter logic [ILEN-1:0] NOP     = 'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            icache_req_valid,
  output logic [XLEN-1:0] icache_req_addr,
  input  logic            icache_resp_valid,
  input  logic [ILEN-1:0] icache_resp_instr,
  input  logic            stall_i,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_BUF   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [ILEN-1:0] buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [ILEN-1:0] fd_instr_q, fd_instr_d;
  logic [XLEN-1:0] fd_pc_q, fd_pc_d;
  logic            fd_valid_q, fd_valid_d;

  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_inc;

  assign redir_pc = redirect_pc & ~XLEN'(3);
  assign pc_inc   = pc_q + XLEN'(4);

  // The skid buffer already holds the next instruction, so no request is issued in BUF.
  assign icache_req_valid = rst_n && (state_q != S_BUF);
  assign icache_req_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  assign instr_o       = fd_instr_q;
  assign pc_o          = fd_pc_q;
  assign instr_valid_o = fd_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    fd_instr_d   = fd_instr_q;
    fd_pc_d      = fd_pc_q;
    fd_valid_d   = fd_valid_q;
    case (state_q)
      S_FETCH: begin
        if (redirect_valid) begin
          fd_valid_d = 1'b0;
          fd_instr_d = NOP;
          pc_d       = redir_pc;
          if (!icache_resp_valid) begin
            // The icache keeps the old address until it answers; wait that out.
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end else if (icache_resp_valid) begin
          pc_d = pc_inc;
          if (!stall_i) begin
            fd_instr_d = icache_resp_instr;
            fd_pc_d    = pc_q;
            fd_valid_d = 1'b1;
          end else begin
            buf_instr_d = icache_resp_instr;
            buf_pc_d    = pc_q;
            state_d     = S_BUF;
          end
        end else if (!stall_i) begin
          fd_valid_d = 1'b0;
          fd_instr_d = NOP;
        end
      end
      S_BUF: begin
        if (redirect_valid) begin
          fd_valid_d = 1'b0;
          fd_instr_d = NOP;
          pc_d       = redir_pc;
          state_d    = S_FETCH;
        end else if (!stall_i) begin
          fd_instr_d = buf_instr_q;
          fd_pc_d    = buf_pc_q;
          fd_valid_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_DRAIN: begin
        fd_valid_d = 1'b0;
        fd_instr_d = NOP;
        if (redirect_valid) pc_d = redir_pc;
        if (icache_resp_valid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= BOOT_PC;
      drain_addr_q <= '0;
      buf_instr_q  <= '0;
      buf_pc_q     <= '0;
      fd_instr_q   <= NOP;
      fd_pc_q      <= '0;
      fd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      fd_instr_q   <= fd_instr_d;
      fd_pc_q      <= fd_pc_d;
      fd_valid_q   <= fd_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: icache responder with per-address latency, decode-side
// scoreboard of expected (pc, instr) pairs, and a second instance booting near the top of memory.
module tb_fetch_stage;

  localparam logic [31:0] NOPI = 32'h0000_0013;
  localparam logic [31:0] BOOT = 32'h0000_1000;
  localparam logic [31:0] WBOOT = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, resp_valid, stall, redirect, instr_valid;
  logic [31:0] req_addr, resp_instr, redirect_pc, instr, pc;

  logic        w_req_valid, w_resp_valid, w_instr_valid;
  logic [31:0] w_req_addr, w_resp_instr, w_instr, w_pc;
  logic        w_stall, w_redirect;
  logic [31:0] w_redirect_pc;

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req_valid(req_valid), .icache_req_addr(req_addr),
    .icache_resp_valid(resp_valid), .icache_resp_instr(resp_instr),
    .stall_i(stall), .redirect_valid(redirect), .redirect_pc(redirect_pc),
    .instr_o(instr), .pc_o(pc), .instr_valid_o(instr_valid)
  );

  fetch_stage #(.BOOT_PC(WBOOT)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .icache_req_valid(w_req_valid), .icache_req_addr(w_req_addr),
    .icache_resp_valid(w_resp_valid), .icache_resp_instr(w_resp_instr),
    .stall_i(w_stall), .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .instr_o(w_instr), .pc_o(w_pc), .instr_valid_o(w_instr_valid)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_t;
  fd_t sb[$];

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  logic [31:0] pc_m, paddr, miss_addr, wpc_m;
  int unsigned cnt, miss_lat;
  bit pending, draining, buf_m, resp_en, wstarted;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    pc_m = BOOT; pending = 0; draining = 0; buf_m = 0; cnt = 0; paddr = '0;
    wpc_m = WBOOT; wstarted = 0; resp_en = 1;
  endtask

  // One cycle: drive at the negedge, check settled outputs, advance the reference model.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    bit give;
    fd_t e;
    @(negedge clk);
    stall = st; redirect = rd; redirect_pc = rpc;
    chk("req_valid", {31'b0, req_valid}, {31'b0, !buf_m});
    give = 0;
    if (req_valid) begin
      if (!pending) begin
        pending = 1; cnt = 0; paddr = req_addr;
        chk("req_addr", req_addr, pc_m);
      end else chk("req_stable", req_addr, paddr);
    end
    if (pending && resp_en) begin
      if (cnt >= ((paddr == miss_addr) ? miss_lat : 0)) give = 1;
      else cnt++;
    end
    resp_valid = give;
    resp_instr = give ? mem(paddr) : 32'h0;
    if (give) pending = 0;

    if (instr_valid && !st) begin
      if (sb.size() == 0) chk("fd_unexpected_valid", {31'b0, instr_valid}, 32'h0);
      else begin
        e = sb.pop_front();
        chk("fd_pc", pc, e.pc);
        chk("fd_instr", instr, e.instr);
      end
    end
    if (!instr_valid) chk("fd_nop", instr, NOPI);

    if (buf_m && !st && !rd) buf_m = 0;
    if (give) begin
      if (draining) draining = 0;
      else if (!rd) begin
        sb.push_back('{pc: pc_m, instr: mem(pc_m)});
        pc_m = pc_m + 32'd4;
        if (st) buf_m = 1;
      end
    end
    if (rd) begin
      sb.delete();
      pc_m = rpc & ~32'd3;
      buf_m = 0;
      if (pending) draining = 1;
    end

    w_resp_valid = w_req_valid;
    w_resp_instr = mem(w_req_addr);
    chk("wrap_req_addr", w_req_addr, wpc_m);
    if (wstarted) begin
      chk("wrap_pc", w_pc, wpc_m - 32'd4);
      chk("wrap_valid", {31'b0, w_instr_valid}, 32'h1);
    end
    wstarted = 1;
    wpc_m = wpc_m + 32'd4;
  endtask

  initial begin
    stall = 0; redirect = 0; redirect_pc = '0; resp_valid = 0; resp_instr = '0;
    w_stall = 0; w_redirect = 0; w_redirect_pc = '0; w_resp_valid = 0; w_resp_instr = '0;
    model_reset();
    miss_addr = 32'h1004; miss_lat = 3;

    repeat (2) @(negedge clk);
    chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, NOPI);
    chk("rst_wrap_req_valid", {31'b0, w_req_valid}, 32'h0);
    chk("rst_wrap_valid", {31'b0, w_instr_valid}, 32'h0);
    rst_n = 1'b1;

    // Hit at 1000, then a 3-cycle miss on 1004
    repeat (5) step(0, 0, '0);
    // Decode stalls as 1008 returns
    repeat (4) step(1, 0, '0);
    repeat (2) step(0, 0, '0);
    // Redirect during a miss on 1010
    miss_addr = 32'h1010; miss_lat = 4;
    step(0, 0, '0);
    step(0, 1, 32'h2000);
    repeat (4) step(0, 0, '0);
    // Redirect together with stall while buffered; low bits of target ignored
    step(1, 0, '0);
    step(1, 1, 32'h3003);
    step(0, 0, '0);
    // Redirect on a same-cycle hit, then repeated redirects while draining
    step(0, 1, 32'h4000);
    miss_addr = 32'h4000; miss_lat = 3;
    step(0, 0, '0);
    step(0, 1, 32'h5000);
    step(0, 1, 32'h6000);
    repeat (3) step(0, 0, '0);
    // Asynchronous reset in the middle of a miss
    miss_addr = 32'h6008; miss_lat = 5;
    step(0, 0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_instr", instr, NOPI);
    stall = 0; redirect = 0; resp_valid = 0; w_resp_valid = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 0, '0);
    resp_en = 0;
    repeat (2) step(0, 0, '0);
    chk("sb_empty", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
